// File: rtl/fifo_write_packer_pkg.sv
// fifo_write_packer_pkg
//   Shared definitions for the byte-to-word FIFO write packer:
//   - out_state_e : output register state (EMPTY / PENDING)
//   - default widths and the lane count / lane-index width helpers
package fifo_write_packer_pkg;

    typedef enum logic {
        EMPTY   = 1'b0,
        PENDING = 1'b1
    } out_state_e;

    localparam int DEF_IN_WIDTH   = 8;
    localparam int DEF_DATA_WIDTH = 32;

    function automatic int calc_lanes(input int in_w, input int data_w);
        return data_w / in_w;
    endfunction

    // A single-lane packer still needs a 1-bit index register.
    function automatic int calc_idx_w(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/fifo_write_packer.sv
// fifo_write_packer
//   Packs IN_WIDTH-bit bytes from a valid/ready stream into DATA_WIDTH-bit
//   words and pushes them into an async FIFO write port.
//
// Ports
//   w_clk    in   write-domain clock (rising edge)
//   nRST     in   asynchronous active-low reset
//   S_VALID  in   upstream byte valid
//   S_READY  out  byte accepted this cycle when S_VALID is high
//   S_DATA   in   upstream byte
//   S_LAST   in   byte closes the current word; remaining lanes are zero
//   W_nEN    out  active-low FIFO push strobe
//   W_DATA   out  word presented to the FIFO (the output register)
//   W_FULL   in   FIFO full, write domain
//   WORD_CNT out  words pushed since reset (wraps)
//   BUSY     out  partial word held or word pending
//
// Output register states
//   state   | meaning
//   EMPTY   | no word waiting for the FIFO
//   PENDING | W_DATA holds a word not yet pushed
module fifo_write_packer
    import fifo_write_packer_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MSB_FIRST  = 0
) (
    input  logic                  w_clk,
    input  logic                  nRST,
    input  logic                  S_VALID,
    output logic                  S_READY,
    input  logic [IN_WIDTH-1:0]   S_DATA,
    input  logic                  S_LAST,
    output logic                  W_nEN,
    output logic [DATA_WIDTH-1:0] W_DATA,
    input  logic                  W_FULL,
    output logic [31:0]           WORD_CNT,
    output logic                  BUSY
);

    localparam int LANES  = calc_lanes(IN_WIDTH, DATA_WIDTH);
    localparam int LIDX_W = calc_idx_w(LANES);
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);

    out_state_e              state_q,    state_d;
    logic [LIDX_W-1:0]       lane_idx_q, lane_idx_d;
    logic [DATA_WIDTH-1:0]   asm_q,      asm_d;
    logic [DATA_WIDTH-1:0]   out_q,      out_d;
    logic [31:0]             word_cnt_q, word_cnt_d;

    logic                    push;
    logic                    accept;
    logic                    complete;
    logic [LIDX_W-1:0]       lane_pos;
    logic [DATA_WIDTH-1:0]   asm_wr;

    // Stall only when a word is waiting and the FIFO cannot take it; a
    // completing byte can therefore never overwrite an unpushed word.
    assign S_READY  = !((state_q == PENDING) && W_FULL);
    assign push     = (state_q == PENDING) && !W_FULL;
    assign accept   = S_VALID && S_READY;
    assign complete = accept && ((lane_idx_q == LAST_LANE) || S_LAST);

    assign W_nEN    = !push;
    assign W_DATA   = out_q;
    assign WORD_CNT = word_cnt_q;
    assign BUSY     = (lane_idx_q != '0) || (state_q == PENDING);

    always_comb begin
        lane_pos = (MSB_FIRST != 0) ? (LAST_LANE - lane_idx_q) : lane_idx_q;
        asm_wr   = asm_q;
        asm_wr[int'(lane_pos) * IN_WIDTH +: IN_WIDTH] = S_DATA;

        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        asm_d      = asm_q;
        out_d      = out_q;
        word_cnt_d = word_cnt_q + (push ? 32'd1 : 32'd0);

        if (complete) begin
            // A push on the same edge is absorbed: the new word replaces the
            // one leaving, so the output stays PENDING without a bubble.
            out_d      = asm_wr;
            asm_d      = '0;
            lane_idx_d = '0;
            state_d    = PENDING;
        end else begin
            if (accept) begin
                asm_d      = asm_wr;
                lane_idx_d = lane_idx_q + LIDX_W'(1);
            end
            if (push) begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge w_clk or negedge nRST) begin
        if (!nRST) begin
            state_q    <= EMPTY;
            lane_idx_q <= '0;
            asm_q      <= '0;
            out_q      <= '0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
            asm_q      <= asm_d;
            out_q      <= out_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule
